wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
Round-robin Wishbone arbiter that shares one slave-side bus between NM masters. Typical use: wishbone_master packet bridges and the CPU data port share the wbcrouter master port.
Grant is held for a whole cycle (cyc-locked), so a multi-beat burst is never split.
A stall watchdog terminates hung transfers with err so that no master can lock the bus.

Parameters:
NM, 2, number of masters (2..4)
AW, 16, address width
DW, 16, data width
SW, DW/8, byte-select width
TIMEOUT, 16, cycles of unacknowledged strobe before the watchdog aborts (>=2)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
i_mcyc  in  NM  master cyc, bit n = master n
i_mstb  in  NM  master stb
i_mwe  in  NM  master we
i_maddr  in  NM*AW  master addresses, master n at [n*AW +: AW]
i_mdata  in  NM*DW  master write data
i_msel  in  NM*SW  master byte selects
o_mack  out  NM  ack routed to owner only
o_merr  out  NM  err routed to owner only (slave err or watchdog)
o_mdata  out  DW  slave read data, broadcast to all masters
o_scyc  out  1  slave-side cyc
o_sstb  out  1  slave-side stb
o_swe  out  1  slave-side we
o_saddr  out  AW  slave-side address
o_sdata  out  DW  slave-side write data
o_ssel  out  SW  slave-side select
i_sack  in  1  slave ack
i_serr  in  1  slave err
i_sdata  in  DW  slave read data
o_grant  out  NM  one-hot current owner (registered)
o_busy  out  1  high in OWN or ABORT

Behaviour:
- Clock/reset: single clock clk_i; rst_i synchronous, active-high.
- Reset values: state=IDLE, o_grant=0, last=NM-1 (so master 0 has first priority), wdog=0.
- Outputs during reset: o_scyc=o_sstb=0, o_mack=o_merr=0, o_saddr/o_sdata/o_ssel/o_swe=0.
- Reset asserted mid-transfer: every output is deasserted at the next edge; no ack or err is delivered for the in-flight beat.
- State machine: IDLE, OWN, ABORT.
- IDLE:
  - If any i_mcyc is high, pick the first requester searching from last+1 upward, modulo NM.
  - Register it into o_grant and last, then go to OWN.
  - Arbitration latency is 1 cycle: cyc seen at edge k gives o_scyc at edge k+1.
  - o_scyc=0 while in IDLE.
- OWN:
  - Owner's cyc/stb/we/addr/data/sel are driven combinationally onto the slave side.
  - Non-owner signals are ignored.
  - o_mack[owner] = i_sack & i_mstb[owner].
  - o_merr[owner] = i_serr & i_mstb[owner].
  - Exit: owner's i_mcyc low → IDLE. Slave cyc drops in that same cycle, and at least one idle cycle always follows before any new grant.
- Watchdog:
  - In OWN, wdog increments on each cycle with o_sstb=1 and neither i_sack nor i_serr.
  - wdog clears on ack, on err, or when stb is low.
  - When wdog reaches TIMEOUT-1 with no response: pulse o_merr[owner] for 1 cycle, force o_scyc=o_sstb=0 from the next cycle, go to ABORT.
- ABORT:
  - Slave side is held idle and acks are discarded.
  - Leave to IDLE when owner's i_mcyc is low.
- Simultaneous events:
  - i_sack & i_serr together: err wins, ack is suppressed.
  - Slave ack in the same cycle as watchdog expiry: ack wins, wdog clears, no abort.
  - Ack arriving while owner's stb=0: dropped.
- Fairness: a master that just released is lowest priority next round. With NM masters continuously requesting, each waits at most NM-1 tenures.
- o_grant is one-hot or zero, never multi-hot.

Decomposition:
- Shared package wb_pkg holds: state encoding (IDLE=0, OWN=1, ABORT=2), default TIMEOUT constant, and the $clog2-based widths for the owner index and wdog.
- One natural sub-module: rr_pick.
  - Combinational rotate-priority encoder.
  - Inputs: req[NM], last index.
  - Outputs: one-hot grant, index, valid.
  - Reusable by the wbcrouter err path.

Test Plan:
1. Single master 0 writes 0x2211 to 0x3000, slave acks 1 cycle after stb. Required: o_scyc rises one cycle after i_mcyc[0], o_mack[0] pulses once, o_saddr=0x3000, o_sdata=0x2211, o_grant=01.
2. Masters 0 and 1 raise cyc on the same edge, both read 0x1000 (slave returns 0x1111), each releases after its ack. Required: master 0 is served first, one idle cycle follows, then master 1; o_mack[1] never pulses during master 0's tenure.
3. Master 1 runs a 2-beat burst (0x2000, 0x2001) while master 0 requests mid-burst. Required: both beats complete for master 1 before o_grant switches to 01.
4. Master 0 holds stb and the slave never acks, TIMEOUT=16. Required: o_merr[0] pulses at the 16th stalled cycle, o_scyc=0 from the next cycle, state stays ABORT until i_mcyc[0] drops, then master 1 can be granted.
5. Slave asserts i_sack and i_serr in the same cycle. Required: o_merr[owner]=1, o_mack=0.
6. rst_i asserted during an OWN transfer. Required: at the next edge o_grant=0, o_scyc=0, no ack delivered; after release, master 0 again has first priority.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and width helpers for the Wishbone round-robin arbiter and
// related router blocks.
package wb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN   = 2'd1,
      ST_ABORT = 2'd2
   } state_t;

   localparam int DEFAULT_TIMEOUT = 16;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Watchdog counter only needs to reach TIMEOUT-1.
   function automatic int wdog_width(input int t);
      return (t > 2) ? $clog2(t) : 1;
   endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between the masters, the arbiter and the shared slave port.
interface wb_rr_arbiter_if #(
   parameter int NM = 2,
   parameter int AW = 16,
   parameter int DW = 16,
   parameter int SW = DW / 8
);
   logic [NM-1:0]    i_mcyc;
   logic [NM-1:0]    i_mstb;
   logic [NM-1:0]    i_mwe;
   logic [NM*AW-1:0] i_maddr;
   logic [NM*DW-1:0] i_mdata;
   logic [NM*SW-1:0] i_msel;
   logic [NM-1:0]    o_mack;
   logic [NM-1:0]    o_merr;
   logic [DW-1:0]    o_mdata;
   logic             o_scyc;
   logic             o_sstb;
   logic             o_swe;
   logic [AW-1:0]    o_saddr;
   logic [DW-1:0]    o_sdata;
   logic [SW-1:0]    o_ssel;
   logic             i_sack;
   logic             i_serr;
   logic [DW-1:0]    i_sdata;
   logic [NM-1:0]    o_grant;
   logic             o_busy;

   // Arbiter view: slave to the masters, driver of the shared port.
   modport slave (
      input  i_mcyc, i_mstb, i_mwe, i_maddr, i_mdata, i_msel,
      input  i_sack, i_serr, i_sdata,
      output o_mack, o_merr, o_mdata,
      output o_scyc, o_sstb, o_swe, o_saddr, o_sdata, o_ssel,
      output o_grant, o_busy
   );

   // Environment view: masters plus the downstream slave.
   modport master (
      output i_mcyc, i_mstb, i_mwe, i_maddr, i_mdata, i_msel,
      output i_sack, i_serr, i_sdata,
      input  o_mack, o_merr, o_mdata,
      input  o_scyc, o_sstb, o_swe, o_saddr, o_sdata, o_ssel,
      input  o_grant, o_busy
   );
endinterface

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: first requester strictly after 'last', wrapping,
// so the previous owner is always considered last.
module rr_pick
   import wb_pkg::*;
#(
   parameter int NM = 2,
   parameter int IW = idx_width(NM)
)(
   input  logic [NM-1:0] req,
   input  logic [IW-1:0] last,
   output logic [NM-1:0] grant,
   output logic [IW-1:0] idx,
   output logic          valid
);

   always_comb begin : pick
      int n;
      n     = 0;
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      for (int i = 1; i <= NM; i++) begin
         n = (int'(last) + i) % NM;
         if (!valid && req[IW'(n)]) begin
            valid            = 1'b1;
            idx              = IW'(n);
            grant[IW'(n)]    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Cycle-locked round-robin Wishbone arbiter with a stall watchdog that
// aborts hung transfers with err.
module wb_rr_arbiter
   import wb_pkg::*;
#(
   parameter int NM      = 2,
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int SW      = DW / 8,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
)(
   input logic            clk_i,
   input logic            rst_i,
   wb_rr_arbiter_if.slave bus
);
   // state   | meaning
   // IDLE    | no owner; arbitrate among raised cyc lines
   // OWN     | owner (last) drives the slave port
   // ABORT   | watchdog fired; slave idle until owner drops cyc

   localparam int             IW        = idx_width(NM);
   localparam int             WW        = wdog_width(TIMEOUT);
   localparam logic [WW-1:0]  WDOG_LAST = WW'(TIMEOUT - 1);
   localparam logic [IW-1:0]  LAST_RST  = IW'(NM - 1);

   state_t          state;
   logic [NM-1:0]   grant_q;
   logic [IW-1:0]   last;
   logic [WW-1:0]   wdog;

   logic [NM-1:0]   pick_grant;
   logic [IW-1:0]   pick_idx;
   logic            pick_valid;

   logic [AW-1:0]   maddr_a [NM];
   logic [DW-1:0]   mdata_a [NM];
   logic [SW-1:0]   msel_a  [NM];

   logic            own_act;
   logic            own_cyc;
   logic            own_stb;
   logic            stall;
   logic            expire;

   for (genvar g = 0; g < NM; g++) begin : g_unpack
      assign maddr_a[g] = bus.i_maddr[g*AW +: AW];
      assign mdata_a[g] = bus.i_mdata[g*DW +: DW];
      assign msel_a[g]  = bus.i_msel[g*SW +: SW];
   end

   rr_pick #(.NM(NM), .IW(IW)) u_pick (
      .req   (bus.i_mcyc),
      .last  (last),
      .grant (pick_grant),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   assign own_act = (state == ST_OWN) && !rst_i;
   assign own_cyc = bus.i_mcyc[last];
   assign own_stb = own_cyc & bus.i_mstb[last];
   assign stall   = own_act & own_stb & !bus.i_sack & !bus.i_serr;
   assign expire  = stall && (wdog == WDOG_LAST);

   always_comb begin
      bus.o_scyc  = own_act & own_cyc;
      bus.o_sstb  = own_act & own_stb;
      bus.o_swe   = 1'b0;
      bus.o_saddr = '0;
      bus.o_sdata = '0;
      bus.o_ssel  = '0;
      bus.o_mack  = '0;
      bus.o_merr  = '0;
      if (own_act && own_cyc) begin
         bus.o_swe   = bus.i_mwe[last];
         bus.o_saddr = maddr_a[last];
         bus.o_sdata = mdata_a[last];
         bus.o_ssel  = msel_a[last];
      end
      // err beats ack; expiry only fires when there is no response at all
      if (own_act && own_stb) begin
         bus.o_merr[last] = bus.i_serr | expire;
         bus.o_mack[last] = bus.i_sack & !bus.i_serr;
      end
   end

   assign bus.o_mdata = bus.i_sdata;
   assign bus.o_grant = grant_q;
   assign bus.o_busy  = !rst_i && (state != ST_IDLE);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= ST_IDLE;
         grant_q <= '0;
         last    <= LAST_RST;
         wdog    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               wdog <= '0;
               if (pick_valid) begin
                  grant_q <= pick_grant;
                  last    <= pick_idx;
                  state   <= ST_OWN;
               end
            end
            ST_OWN: begin
               if (!own_cyc) begin
                  state   <= ST_IDLE;
                  grant_q <= '0;
                  wdog    <= '0;
               end else if (expire) begin
                  state <= ST_ABORT;
                  wdog  <= '0;
               end else if (stall) begin
                  wdog <= wdog + 1'b1;
               end else begin
                  wdog <= '0;
               end
            end
            ST_ABORT: begin
               wdog <= '0;
               if (!own_cyc) begin
                  state   <= ST_IDLE;
                  grant_q <= '0;
               end
            end
            default: begin
               state   <= ST_IDLE;
               grant_q <= '0;
               wdog    <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: two masters, hand-computed expectations.
module tb_wb_rr_arbiter;

   logic clk_i;
   logic rst_i;
   int   checks;
   int   failures;

   wb_rr_arbiter_if #(.NM(2), .AW(16), .DW(16), .SW(2)) bus ();

   wb_rr_arbiter #(.NM(2), .AW(16), .DW(16), .SW(2), .TIMEOUT(16)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus.slave)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.i_mcyc  = 2'b00;
      bus.i_mstb  = 2'b00;
      bus.i_mwe   = 2'b00;
      bus.i_maddr = '0;
      bus.i_mdata = '0;
      bus.i_msel  = '0;
      bus.i_sack  = 1'b0;
      bus.i_serr  = 1'b0;
      bus.i_sdata = '0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      checks   = 0;
      failures = 0;
      rst_i    = 1'b1;
      idle_inputs();
      tick();
      tick();
      // reset state
      chk("rst_grant", 32'(bus.o_grant), 32'h0);
      chk("rst_scyc",  32'(bus.o_scyc),  32'h0);
      chk("rst_busy",  32'(bus.o_busy),  32'h0);
      chk("rst_mack",  32'(bus.o_mack),  32'h0);
      rst_i = 1'b0;
      tick();

      // 1: single write from master 0
      bus.i_mcyc = 2'b01; bus.i_mstb = 2'b01; bus.i_mwe = 2'b01;
      bus.i_maddr[15:0] = 16'h3000; bus.i_mdata[15:0] = 16'h2211; bus.i_msel[1:0] = 2'b11;
      #1;
      chk("t1_idle_scyc", 32'(bus.o_scyc), 32'h0);
      tick();
      chk("t1_scyc",  32'(bus.o_scyc),  32'h1);
      chk("t1_grant", 32'(bus.o_grant), 32'h1);
      chk("t1_saddr", 32'(bus.o_saddr), 32'h3000);
      chk("t1_sdata", 32'(bus.o_sdata), 32'h2211);
      chk("t1_swe",   32'(bus.o_swe),   32'h1);
      chk("t1_noack", 32'(bus.o_mack),  32'h0);
      bus.i_sack = 1'b1;
      #1;
      chk("t1_mack", 32'(bus.o_mack), 32'h1);
      tick();
      bus.i_mcyc = 2'b00; bus.i_mstb = 2'b00; bus.i_sack = 1'b0;
      #1;
      chk("t1_drop_scyc", 32'(bus.o_scyc), 32'h0);
      chk("t1_drop_mack", 32'(bus.o_mack), 32'h0);
      tick();
      chk("t1_end_grant", 32'(bus.o_grant), 32'h0);
      chk("t1_end_busy",  32'(bus.o_busy),  32'h0);

      // 2: simultaneous reads, master 0 first after reset
      do_reset();
      bus.i_mcyc = 2'b11; bus.i_mstb = 2'b11; bus.i_mwe = 2'b00;
      bus.i_maddr = {16'h1000, 16'h1000};
      tick();
      chk("t2_grant0", 32'(bus.o_grant), 32'h1);
      bus.i_sack = 1'b1; bus.i_sdata = 16'h1111;
      #1;
      chk("t2_mack0",  32'(bus.o_mack),  32'h1);
      chk("t2_mdata0", 32'(bus.o_mdata), 32'h1111);
      tick();
      bus.i_mcyc = 2'b10; bus.i_mstb = 2'b10; bus.i_sack = 1'b0;
      #1;
      chk("t2_rel_mack", 32'(bus.o_mack), 32'h0);
      tick();
      chk("t2_gap_scyc",  32'(bus.o_scyc),  32'h0);
      chk("t2_gap_grant", 32'(bus.o_grant), 32'h0);
      tick();
      chk("t2_grant1", 32'(bus.o_grant), 32'h2);
      chk("t2_saddr1", 32'(bus.o_saddr), 32'h1000);
      bus.i_sack = 1'b1;
      #1;
      chk("t2_mack1", 32'(bus.o_mack), 32'h2);
      tick();
      bus.i_mcyc = 2'b00; bus.i_mstb = 2'b00; bus.i_sack = 1'b0;
      tick();

      // 3: master 1 burst, master 0 arrives mid-burst
      bus.i_mcyc = 2'b10; bus.i_mstb = 2'b10; bus.i_mwe = 2'b10;
      bus.i_maddr[31:16] = 16'h2000;
      tick();
      chk("t3_grant1", 32'(bus.o_grant), 32'h2);
      bus.i_mcyc = 2'b11; bus.i_mstb = 2'b11; bus.i_maddr[15:0] = 16'h4000;
      bus.i_sack = 1'b1;
      #1;
      chk("t3_b0_addr", 32'(bus.o_saddr), 32'h2000);
      chk("t3_b0_ack",  32'(bus.o_mack),  32'h2);
      tick();
      bus.i_maddr[31:16] = 16'h2001;
      #1;
      chk("t3_b1_addr",  32'(bus.o_saddr), 32'h2001);
      chk("t3_b1_ack",   32'(bus.o_mack),  32'h2);
      chk("t3_b1_grant", 32'(bus.o_grant), 32'h2);
      tick();
      bus.i_mcyc = 2'b01; bus.i_mstb = 2'b01; bus.i_sack = 1'b0;
      #1;
      chk("t3_rel_scyc", 32'(bus.o_scyc), 32'h0);
      tick();
      chk("t3_gap_grant", 32'(bus.o_grant), 32'h0);
      tick();
      chk("t3_grant0", 32'(bus.o_grant), 32'h1);
      chk("t3_saddr0", 32'(bus.o_saddr), 32'h4000);
      bus.i_mcyc = 2'b00; bus.i_mstb = 2'b00;
      tick();
      tick();

      // 4: watchdog abort on master 0
      bus.i_mcyc = 2'b01; bus.i_mstb = 2'b01; bus.i_maddr[15:0] = 16'h5000;
      tick();
      for (int k = 1; k <= 16; k++) begin
         if (k < 16) chk("t4_stall_noerr", 32'(bus.o_merr), 32'h0);
         else        chk("t4_expire_err",  32'(bus.o_merr), 32'h1);
         tick();
      end
      chk("t4_abort_scyc",  32'(bus.o_scyc),  32'h0);
      chk("t4_abort_sstb",  32'(bus.o_sstb),  32'h0);
      chk("t4_abort_merr",  32'(bus.o_merr),  32'h0);
      chk("t4_abort_busy",  32'(bus.o_busy),  32'h1);
      bus.i_mcyc = 2'b11; bus.i_mstb = 2'b11; bus.i_sack = 1'b1;
      #1;
      chk("t4_abort_noack", 32'(bus.o_mack), 32'h0);
      tick();
      tick();
      chk("t4_abort_hold", 32'(bus.o_scyc), 32'h0);
      bus.i_mcyc = 2'b10; bus.i_mstb = 2'b10; bus.i_sack = 1'b0;
      #1;
      chk("t4_abort_busy2", 32'(bus.o_busy), 32'h1);
      tick();
      chk("t4_idle_grant", 32'(bus.o_grant), 32'h0);
      tick();
      chk("t4_grant1", 32'(bus.o_grant), 32'h2);
      chk("t4_scyc1",  32'(bus.o_scyc),  32'h1);
      bus.i_mcyc = 2'b00; bus.i_mstb = 2'b00;
      tick();
      tick();

      // 5: ack at expiry wins, ack with stb low dropped, ack+err -> err
      bus.i_mcyc = 2'b01; bus.i_mstb = 2'b01;
      tick();
      for (int k = 1; k <= 15; k++) tick();
      bus.i_sack = 1'b1;
      #1;
      chk("t5_edge_ack", 32'(bus.o_mack), 32'h1);
      chk("t5_edge_err", 32'(bus.o_merr), 32'h0);
      tick();
      bus.i_sack = 1'b0;
      #1;
      chk("t5_noabort_scyc", 32'(bus.o_scyc), 32'h1);
      chk("t5_noabort_err",  32'(bus.o_merr), 32'h0);
      bus.i_mstb = 2'b00; bus.i_sack = 1'b1;
      #1;
      chk("t5_nostb_ack", 32'(bus.o_mack), 32'h0);
      tick();
      bus.i_mstb = 2'b01; bus.i_serr = 1'b1;
      #1;
      chk("t5_both_err", 32'(bus.o_merr), 32'h1);
      chk("t5_both_ack", 32'(bus.o_mack), 32'h0);
      tick();
      bus.i_mcyc = 2'b00; bus.i_mstb = 2'b00; bus.i_sack = 1'b0; bus.i_serr = 1'b0;
      tick();
      tick();

      // 6: reset during master 1 tenure
      bus.i_mcyc = 2'b10; bus.i_mstb = 2'b10;
      tick();
      chk("t6_grant1", 32'(bus.o_grant), 32'h2);
      rst_i = 1'b1; bus.i_mcyc = 2'b11; bus.i_mstb = 2'b11; bus.i_sack = 1'b1;
      #1;
      chk("t6_rst_noack", 32'(bus.o_mack), 32'h0);
      chk("t6_rst_scyc",  32'(bus.o_scyc), 32'h0);
      tick();
      chk("t6_rst_grant", 32'(bus.o_grant), 32'h0);
      chk("t6_rst_busy",  32'(bus.o_busy),  32'h0);
      rst_i = 1'b0; bus.i_sack = 1'b0;
      tick();
      chk("t6_first_m0", 32'(bus.o_grant), 32'h1);
      bus.i_mcyc = 2'b00; bus.i_mstb = 2'b00;
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
